seg_display_arbiter: RTL
========================

Name: seg_display_arbiter

Overview:
- Shares the single 8-digit seven-segment display driver between up to N_REQ requesters, such as the PC monitor, register probe and memory probe.
- Grants the display round-robin, holds each grant for a minimum dwell time, and supports a lock to freeze the current owner.
- Drives the driver's 32-bit hex value input and 8-bit digit-enable input from registers.
- Reports which requester currently owns the display.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DWELL_CYCLES, 100000000, minimum grant length in clk_100M cycles (1 s at 100 MHz); must be >= 2.
- CNT_W, 27, dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES.

Ports:
- clk_100M  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester display request, level-sensitive.
- data  input  32*N_REQ  requester i value in bits [32i+31:32i], one nibble per digit.
- mask  input  8*N_REQ  requester i digit enables in bits [8i+7:8i].
- lock  input  1  when high, the current owner keeps the display past dwell expiry.
- gnt  output  N_REQ  one-hot grant, registered; all-zero when idle.
- disp_in  output  32  value to the display driver, registered.
- disp_en  output  8  digit enables to the display driver, registered; 0 blanks all digits.
- busy  output  1  high whenever gnt != 0.

Behaviour:
- Reset (async, rst_n low): gnt=0, disp_in=0, disp_en=0, busy=0, dwell counter=0, state=IDLE, last-grant pointer=N_REQ-1 so requester 0 has first priority. Leaving reset is synchronous to the next edge.
- States: IDLE, SHOW.
- IDLE:
  - req==0: stay; disp_en=0; disp_in holds its last value.
  - Any req bit set: on the next edge, grant the first set bit scanning upward from pointer+1 modulo N_REQ. gnt, disp_in=data[k], disp_en=mask[k], pointer=k and counter=0 all load on that same edge. Move to SHOW.
- SHOW, owner k:
  - Each cycle, disp_in<=data[k] and disp_en<=mask[k]. Source-to-display latency is 1 cycle.
  - Counter increments each cycle and saturates at DWELL_CYCLES-1.
- Owner drop, req[k]==0:
  - Re-arbitrate on the next edge, excluding k.
  - No other request: go to IDLE with gnt=0 and disp_en=0.
  - Otherwise: grant the next requester round-robin; counter=0.
  - Owner drop takes precedence over dwell expiry and lock.
- Dwell expiry, counter==DWELL_CYCLES-1, req[k]==1:
  - lock=0 and another req set: grant the next set bit after k round-robin; counter=0. gnt and display change on the same edge.
  - lock=0 and no other req: keep k; counter restarts at 0.
  - lock=1: keep k; counter holds saturated. The switch happens on the first cycle lock is low, if another request is pending.
- Lock effects:
  - lock is ignored in IDLE.
  - lock never blocks an owner drop.
- Requester arriving mid-dwell: does not pre-empt the owner. It waits for dwell expiry or owner drop.
- gnt is always one-hot or zero; busy == |gnt.
- Reset asserted mid-grant: outputs clear immediately (asynchronously) to their reset values.

Decomposition:
- Package seg_arb_pkg:
  - state encoding: IDLE=1'b0, SHOW=1'b1;
  - default DWELL_CYCLES;
  - blank-mask constant 8'h00.
- Sub-module rr_pick, purely combinational:
  - inputs: request vector, exclude-index enable, last pointer;
  - outputs: one-hot next grant, its index, and a valid flag.
- The FSM, dwell counter and output registers stay in seg_display_arbiter.

Test Plan (bench uses N_REQ=4, DWELL_CYCLES=8):
- Reset then req=4'b0000 for 20 cycles -> gnt=0, disp_en=8'h00, busy=0 throughout.
- req=4'b0101, data0=32'h1234_5678, mask0=8'hFF -> one edge later gnt=4'b0001, disp_in=32'h12345678, disp_en=8'hFF. After 8 cycles of SHOW, gnt=4'b0100 and disp_in=data2.
- Owner 0 granted; change data0 to 32'hDEAD_BEEF mid-dwell -> disp_in shows 32'hDEADBEEF exactly 1 cycle later, and gnt is unchanged.
- lock=1 with owner 1 and req=4'b1010 for 30 cycles -> gnt stays 4'b0010. Drop lock -> gnt=4'b1000 on the next edge.
- Owner 2; drop req[2] on the same cycle the counter reaches 7 with lock=1 and req[3]=1 -> gnt=4'b1000 on the next edge (drop wins over lock).
- Assert rst_n=0 asynchronously mid-SHOW -> gnt=0, disp_in=0, disp_en=0 before the next clock edge. After release with req=4'b1111, the first grant is 4'b0001.

Source files
------------

// File: rtl/seg_arb_pkg.sv
// Shared definitions for the seven-segment display arbiter.
//   state_e              : arbiter FSM state (IDLE / SHOW)
//   DEFAULT_DWELL_CYCLES : default minimum grant length (1 s at 100 MHz)
//   BLANK_MASK           : digit-enable value that blanks every digit
package seg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_DWELL_CYCLES = 100000000;
  localparam logic [7:0]  BLANK_MASK           = 8'h00;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req      : request vector
//   excl_en  : when high, the requester at last_ptr is not eligible
//   last_ptr : index of the most recent grant; scanning starts at last_ptr+1
//   gnt_oh   : one-hot winner (all-zero when none)
//   gnt_idx  : index of the winner
//   valid    : a winner exists
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic             excl_en,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             valid
);

  logic [N_REQ-1:0] eligible;
  int unsigned      base;
  int unsigned      idx;
  logic [PTR_W-1:0] idx_p;

  always_comb begin
    gnt_oh   = '0;
    gnt_idx  = '0;
    valid    = 1'b0;
    idx      = 0;
    idx_p    = '0;
    eligible = req;
    if (excl_en) begin
      eligible[last_ptr] = 1'b0;
    end
    base = {{(32-PTR_W){1'b0}}, last_ptr};
    // last_ptr itself is visited last, so it only wins when nobody else asks
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx   = (base + i) % N_REQ;
      idx_p = PTR_W'(idx);
      if (!valid && eligible[idx_p]) begin
        valid   = 1'b1;
        gnt_idx = idx_p;
      end
    end
    if (valid) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment driver between
// N_REQ requesters, with a minimum dwell per grant and an owner lock.
//   clk_100M : system clock
//   rst_n    : asynchronous active-low reset
//   req      : per-requester level request
//   data     : requester i value in [32i+31:32i]
//   mask     : requester i digit enables in [8i+7:8i]
//   lock     : keep current owner past dwell expiry
//   gnt      : registered one-hot grant (zero when idle)
//   disp_in  : registered value to the display driver
//   disp_en  : registered digit enables (0 blanks)
//   busy     : |gnt
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int unsigned CNT_W        = 27
) (
  input  logic                  clk_100M,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   data,
  input  logic [8*N_REQ-1:0]    mask,
  input  logic                  lock,
  output logic [N_REQ-1:0]      gnt,
  output logic [31:0]           disp_in,
  output logic [7:0]            disp_en,
  output logic                  busy
);

  localparam int unsigned      PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [31:0]      disp_in_q, disp_in_d;
  logic [7:0]       disp_en_q, disp_en_d;

  logic [N_REQ-1:0] pick_oh;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;
  logic             excl_en;

  logic [31:0]      data_arr [N_REQ];
  logic [7:0]       mask_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = data[32*g +: 32];
    assign mask_arr[g] = mask[8*g +: 8];
  end

  // While showing, the owner is never a re-arbitration candidate; if nobody
  // else is pending the picker reports no winner and the owner is kept.
  assign excl_en = (state_q == SHOW);

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req      (req),
    .excl_en  (excl_en),
    .last_ptr (ptr_q),
    .gnt_oh   (pick_oh),
    .gnt_idx  (pick_idx),
    .valid    (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    disp_in_d = disp_in_q;
    disp_en_d = disp_en_q;

    case (state_q)
      IDLE: begin
        gnt_d     = '0;
        disp_en_d = BLANK_MASK;
        if (pick_vld) begin
          state_d = SHOW;
          ptr_d   = pick_idx;
          gnt_d   = pick_oh;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (!req[ptr_q]) begin
          // owner drop beats dwell and lock
          cnt_d = '0;
          if (pick_vld) begin
            ptr_d = pick_idx;
            gnt_d = pick_oh;
          end else begin
            state_d   = IDLE;
            gnt_d     = '0;
            disp_en_d = BLANK_MASK;
          end
        end else if (cnt_q == CNT_LAST) begin
          // locked: counter stays saturated so the switch fires on unlock
          if (!lock) begin
            cnt_d = '0;
            if (pick_vld) begin
              ptr_d = pick_idx;
              gnt_d = pick_oh;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == SHOW) begin
      disp_in_d = data_arr[ptr_d];
      disp_en_d = mask_arr[ptr_d];
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_INIT;
      cnt_q     <= '0;
      gnt_q     <= '0;
      disp_in_q <= '0;
      disp_en_q <= BLANK_MASK;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      disp_in_q <= disp_in_d;
      disp_en_q <= disp_en_d;
    end
  end

  assign gnt     = gnt_q;
  assign disp_in = disp_in_q;
  assign disp_en = disp_en_q;
  assign busy    = |gnt_q;

endmodule
